// File: rtl/vga_pkg.sv
// vga_pkg: VGA 640x400 timing constants, framebuffer geometry and the RAM access kinds shared by the scanout path.
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int H_WHOLE = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 400;
  localparam int V_FRONT = 12;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 35;
  localparam int V_WHOLE = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int FB_ADDR_W = 14;
  localparam int FB_DATA_W = 16;
  localparam int FRAME_WORDS = (H_VISIBLE * V_VISIBLE) / 16;
  typedef enum logic [1:0] {MEM_IDLE, MEM_FETCH, MEM_WRITE} mem_op_e;
endpackage

// File: rtl/vga_scan_fifo.sv
// vga_scan_fifo: synchronous show-ahead FIFO holding prefetched scanout words.
module vga_scan_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      assert (!(push && !pop && count == CNT_W'(DEPTH)));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  always_ff @(posedge clock)
    if (push && !flush) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single-port framebuffer RAM between deadline-driven scanout prefetch and host writes.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = vga_pkg::FB_ADDR_W,
  parameter int DATA_W = vga_pkg::FB_DATA_W,
  parameter int FRAME_WORDS = vga_pkg::FRAME_WORDS,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_SCAN_RUN = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              scan_pop,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  output logic              underrun,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RUN_W = $clog2(MAX_SCAN_RUN + 1);
  logic [ADDR_W-1:0] fetch_addr;
  logic frame_done, inflight;
  logic [RUN_W-1:0] run_cnt;
  logic [CNT_W-1:0] count, reserved;
  logic [DATA_W-1:0] head;
  logic fetch_issue, host_fire, force_host, fifo_pop, fifo_push, last_word;
  mem_op_e mem_op;
  vga_scan_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .flush(frame_start),
    .push(fifo_push),
    .push_data(mem_rdata),
    .pop(fifo_pop),
    .head(head),
    .count(count)
  );
  // The read in flight already owns a FIFO slot, so the FIFO can never overflow.
  assign reserved = count + CNT_W'(inflight);
  assign force_host = host_valid && run_cnt == RUN_W'(MAX_SCAN_RUN);
  assign fetch_issue = !frame_done && reserved < CNT_W'(FIFO_DEPTH) && !force_host && !frame_start;
  assign host_ready = reset_n && !fetch_issue;
  assign host_fire = host_valid && host_ready;
  assign mem_op = fetch_issue ? MEM_FETCH : host_fire ? MEM_WRITE : MEM_IDLE;
  assign mem_en = mem_op != MEM_IDLE;
  assign mem_we = mem_op == MEM_WRITE;
  assign mem_addr = !reset_n ? '0 : fetch_issue ? fetch_addr : host_addr;
  assign mem_wdata = reset_n ? host_data : '0;
  assign scan_valid = count != '0;
  assign scan_data = scan_valid ? head : '0;
  assign fifo_pop = scan_pop && scan_valid && !frame_start;
  assign fifo_push = inflight && !frame_start;
  assign last_word = fetch_addr == ADDR_W'(FRAME_WORDS - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      fetch_addr <= '0;
      frame_done <= 1'b1;
      inflight <= 1'b0;
      run_cnt <= '0;
      underrun <= 1'b0;
    end else begin
      inflight <= fetch_issue;
      underrun <= !frame_start && (underrun || (scan_pop && !scan_valid));
      run_cnt <= (frame_start || !host_valid || host_fire) ? '0 :
                 (fetch_issue && run_cnt != RUN_W'(MAX_SCAN_RUN)) ? run_cnt + 1'b1 : run_cnt;
      if (frame_start) begin
        fetch_addr <= '0;
        frame_done <= 1'b0;
      end else if (fetch_issue) begin
        frame_done <= last_word;
        if (!last_word) fetch_addr <= fetch_addr + 1'b1;
      end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed and randomized checks of vga_fb_arbiter against a queue-based model of the scanout/host rules.
module tb_vga_fb_arbiter;
  localparam int FW = 16000;
  localparam int DEPTH = 4;
  localparam int MAXRUN = 3;
  logic clock = 0, reset_n = 0, frame_start = 0, scan_pop = 0, host_valid = 0;
  logic [13:0] host_addr = '0;
  logic [15:0] host_data = '0, mem_rdata = '0;
  logic [15:0] scan_data, mem_wdata;
  logic [13:0] mem_addr;
  logic scan_valid, underrun, host_ready, mem_en, mem_we;
  always #5 clock = ~clock;
  vga_fb_arbiter dut (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .scan_pop(scan_pop),
    .scan_data(scan_data), .scan_valid(scan_valid), .underrun(underrun),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data), .host_ready(host_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  int checks = 0, failures = 0;
  logic [15:0] ram [0:16383];
  logic [15:0] q [$];
  bit m_infl = 0, m_done = 1, m_under = 0;
  logic [15:0] m_infl_d = '0;
  int m_addr = 0, m_run = 0, last_fetch = -1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Drive one cycle, check outputs against the model, then advance the model and the RAM.
  task automatic step(input bit fs, input bit sp, input bit hv, input logic [13:0] ha, input logic [15:0] hd);
    bit fetch, acc;
    logic [15:0] rd;
    frame_start = fs; scan_pop = sp; host_valid = hv; host_addr = ha; host_data = hd;
    #3;
    fetch = !m_done && (q.size() + int'(m_infl)) < DEPTH && !(hv && m_run == MAXRUN) && !fs;
    acc = hv && !fetch;
    chk("host_ready", host_ready, !fetch);
    chk("mem_en", mem_en, fetch || acc);
    chk("mem_we", mem_we, acc);
    if (fetch || acc) chk("mem_addr", mem_addr, fetch ? m_addr : ha);
    if (acc) chk("mem_wdata", mem_wdata, hd);
    chk("scan_valid", scan_valid, q.size() != 0);
    if (q.size() != 0) chk("scan_data", scan_data, q[0]);
    chk("underrun", underrun, m_under);
    rd = mem_rdata;
    if (mem_en && !mem_we) rd = ram[mem_addr];
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
    if (fs) begin
      q.delete();
      m_infl = 0; m_addr = 0; m_done = 0; m_run = 0; m_under = 0; last_fetch = -1;
    end else begin
      if (sp) begin
        if (q.size() != 0) void'(q.pop_front());
        else m_under = 1;
      end
      if (m_infl) q.push_back(m_infl_d);
      if (fetch) begin
        m_infl_d = ram[m_addr];
        last_fetch = m_addr;
        if (m_addr == FW - 1) m_done = 1;
        else m_addr++;
      end
      m_infl = fetch;
      m_run = (!hv || acc) ? 0 : (m_run < MAXRUN ? m_run + 1 : m_run);
    end
    @(posedge clock);
    #1;
    mem_rdata = rd;
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 16'($urandom);
    host_valid = 1; host_addr = 14'h1234; host_data = 16'hBEEF; frame_start = 1; scan_pop = 1;
    #12;
    chk("rst_host_ready", host_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_scan_valid", scan_valid, 0);
    chk("rst_scan_data", scan_data, 0);
    chk("rst_underrun", underrun, 0);
    @(posedge clock);
    #1;
    reset_n = 1; host_valid = 0; frame_start = 0; scan_pop = 0;
    repeat (2) step(0, 0, 0, '0, '0);
    // First fill after frame_start: four back-to-back reads then idle.
    step(1, 0, 0, '0, '0);
    repeat (6) step(0, 0, 0, '0, '0);
    step(0, 0, 1, 14'h0100, 16'hA5A5);
    chk("ram_0100", ram[14'h0100], 16'hA5A5);
    for (int i = 0; i < 60; i++) step(0, i[0], 1, 14'($urandom), 16'($urandom));
    // Popping every cycle under host pressure starves the FIFO.
    for (int i = 0; i < 60; i++) step(0, 1, 1, 14'($urandom), 16'($urandom));
    repeat (3) step(0, 0, 0, '0, '0);
    step(1, 1, 0, '0, '0);
    repeat (3) step(0, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    for (int n = 0; n < 50 && last_fetch != 5; n++) step(0, 1, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    repeat (6) step(0, 0, 0, '0, '0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 199) == 0, 1'($urandom), $urandom_range(0, 2) != 0, 14'($urandom), 16'($urandom));
    step(1, 0, 0, '0, '0);
    for (int n = 0; n < 20000 && !(m_done && !m_infl); n++) step(0, q.size() != 0, 0, '0, '0);
    chk("last_fetch", last_fetch, FW - 1);
    step(0, 0, 1, 14'h2AAA, 16'h5A5A);
    repeat (3) step(0, 1, 0, '0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
